// File: rtl/plot_receiver.sv
// rtl/plot_receiver.sv - 160x120 3-bit pixel-plot sink with framebuffer, registered read port and plot statistics
// Optional feature macro: PLOT_RX_COVERAGE_EN (frame_done on full-screen coverage instead of the last-pixel plot)
module plot_receiver #(
    parameter int W = 160,
    parameter int H = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        clear_req,
    input  logic        rd_req,
    input  logic [7:0]  rd_x,
    input  logic [6:0]  rd_y,
    output logic        ready,
    output logic        rd_valid,
    output logic [2:0]  rd_colour,
    output logic        frame_done,
    output logic [15:0] plot_count,
    output logic [7:0]  drop_count
);

    localparam int          NPIX      = W * H;
    localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
    localparam logic [7:0]  W_L       = 8'(W);
    localparam logic [6:0]  H_L       = 7'(H);
    localparam logic [7:0]  X_LAST    = 8'(W - 1);
    localparam logic [6:0]  Y_LAST    = 7'(H - 1);

    typedef enum logic {
        ST_CLEAR  = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] clr_addr_q, clr_addr_d;

    logic [2:0]  fb_mem [0:NPIX-1];
    logic        fb_we;
    logic [14:0] fb_waddr;
    logic [2:0]  fb_wdata;

    logic [14:0] plot_addr;
    logic [14:0] rd_addr;
    logic        plot_in_range;
    logic        rd_in_range;
    logic        plot_accept;
    logic        plot_drop;
    logic        frame_hit;

    logic        rd_valid_q;
    logic [2:0]  rd_colour_q;
    logic        frame_done_q;
    logic [15:0] plot_count_q;
    logic [7:0]  drop_count_q;

    // y*160 + x as (y<<7)+(y<<5)+x; wide enough for the largest out-of-range coordinates too
    assign plot_addr     = ({8'd0, vga_y} << 7) + ({8'd0, vga_y} << 5) + {7'd0, vga_x};
    assign rd_addr       = ({8'd0, rd_y} << 7) + ({8'd0, rd_y} << 5) + {7'd0, rd_x};
    assign plot_in_range = (vga_x < W_L) && (vga_y < H_L);
    assign rd_in_range   = (rd_x < W_L) && (rd_y < H_L);

    // State register and clear-address counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Next state, framebuffer write port and plot accept/drop decode; a clear request overrides everything
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        ready       = 1'b0;
        fb_we       = 1'b0;
        fb_waddr    = clr_addr_q;
        fb_wdata    = 3'd0;
        plot_accept = 1'b0;
        plot_drop   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                fb_we     = 1'b1;
                plot_drop = vga_plot && !clear_req;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_ACTIVE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 15'd1;
                end
            end
            ST_ACTIVE: begin
                ready = 1'b1;
                if (vga_plot && !clear_req) begin
                    if (plot_in_range) begin
                        plot_accept = 1'b1;
                    end else begin
                        plot_drop = 1'b1;
                    end
                end
                fb_we    = plot_accept;
                fb_waddr = plot_addr;
                fb_wdata = vga_colour;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
        if (clear_req) begin
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
        end
    end

    // Framebuffer write port; no reset, the clear sweep initialises it
    always_ff @(posedge clk) begin
        if (fb_we) begin
            fb_mem[fb_waddr] <= fb_wdata;
        end
    end

    // Registered read port; read-first against a same-cycle write because the write is non-blocking
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q  <= 1'b0;
            rd_colour_q <= 3'd0;
        end else begin
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_colour_q <= rd_in_range ? fb_mem[rd_addr] : 3'd0;
            end
        end
    end

`ifdef PLOT_RX_COVERAGE_EN
    logic [NPIX-1:0] cov_q;
    logic [14:0]     uniq_q;
    logic            cov_new;

    assign cov_new   = plot_accept && !cov_q[plot_addr];
    assign frame_hit = cov_new && (uniq_q == LAST_ADDR);

    // Written-since-clear bitmap, swept to zero alongside the framebuffer
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            cov_q[clr_addr_q] <= 1'b0;
        end else if (plot_accept) begin
            cov_q[plot_addr] <= 1'b1;
        end
    end

    // Unique-pixel counter, restarted whenever a clear begins
    always_ff @(posedge clk) begin
        if (rst || clear_req) begin
            uniq_q <= '0;
        end else if (cov_new) begin
            uniq_q <= uniq_q + 15'd1;
        end
    end
`else
    assign frame_hit = plot_accept && (vga_x == X_LAST) && (vga_y == Y_LAST);
`endif

    // Saturating plot statistics and sticky frame-complete flag, zeroed whenever a clear begins
    always_ff @(posedge clk) begin
        if (rst || clear_req) begin
            plot_count_q <= '0;
            drop_count_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            if (plot_accept && (plot_count_q != 16'hFFFF)) begin
                plot_count_q <= plot_count_q + 16'd1;
            end
            if (plot_drop && (drop_count_q != 8'hFF)) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
            if (frame_hit) begin
                frame_done_q <= 1'b1;
            end
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_colour  = rd_colour_q;
    assign frame_done = frame_done_q;
    assign plot_count = plot_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_plot_receiver.sv
// tb/tb_plot_receiver.sv - directed self-checking bench for plot_receiver
module tb_plot_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clear_req;
    logic        rd_req;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic        ready;
    logic        rd_valid;
    logic [2:0]  rd_colour;
    logic        frame_done;
    logic [15:0] plot_count;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

`ifdef PLOT_RX_COVERAGE_EN
    localparam logic EXP_EARLY_DONE = 1'b0;
`else
    localparam logic EXP_EARLY_DONE = 1'b1;
`endif

    always #5 clk = ~clk;

    plot_receiver #(.W(160), .H(120)) dut (
        .clk        (clk),
        .rst        (rst),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .clear_req  (clear_req),
        .rd_req     (rd_req),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .ready      (ready),
        .rd_valid   (rd_valid),
        .rd_colour  (rd_colour),
        .frame_done (frame_done),
        .plot_count (plot_count),
        .drop_count (drop_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_px(input int x, input int y, output logic [2:0] c, output logic v);
        rd_req = 1'b1;
        rd_x   = 8'(x);
        rd_y   = 7'(y);
        tick();
        c      = rd_colour;
        v      = rd_valid;
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic [2:0] c;
        logic v;
        int rx[4] = '{0, 159, 80, 5};
        int ry[4] = '{0, 119, 60, 5};
        rst = 1'b1; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
        clear_req = 1'b0; rd_req = 1'b0; rd_x = '0; rd_y = '0;
        tick();
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
        checks++; if (rd_colour !== 3'd0) begin errors++; $display("FAIL reset_rd_colour got %0d want 0", rd_colour); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0b want 0", frame_done); end
        checks++; if (plot_count !== 16'd0) begin errors++; $display("FAIL reset_plot_count got %0d want 0", plot_count); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
        rst = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 20000) begin
            vga_plot = (n == 100);
            vga_x = 8'd5; vga_y = 7'd5; vga_colour = 3'd7;
            n++;
            tick();
        end
        vga_plot = 1'b0;
        checks++; if (n != 19200) begin errors++; $display("FAIL reset_clear_cycles got %0d want 19200", n); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %0b want 1", ready); end
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL clear_plot_drop got %0d want 1", drop_count); end
        checks++; if (plot_count !== 16'd0) begin errors++; $display("FAIL clear_plot_count got %0d want 0", plot_count); end
        for (int i = 0; i < 4; i++) begin
            read_px(rx[i], ry[i], c, v);
            checks++; if (v !== 1'b1 || c !== 3'd0) begin errors++; $display("FAIL reset_read(%0d,%0d) got v=%0b c=%0d want v=1 c=0", rx[i], ry[i], v, c); end
        end
    endtask

    task automatic test_drops();
        logic [2:0] c;
        logic v;
        int dx[3] = '{160, 0, 255};
        int dy[3] = '{0, 120, 127};
        vga_plot = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vga_x = 8'(dx[i]); vga_y = 7'(dy[i]); vga_colour = 3'd7;
            tick();
        end
        vga_plot = 1'b0;
        checks++; if (drop_count !== 8'd4) begin errors++; $display("FAIL drops_drop_count got %0d want 4", drop_count); end
        checks++; if (plot_count !== 16'd0) begin errors++; $display("FAIL drops_plot_count got %0d want 0", plot_count); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL drops_frame_done got %0b want 0", frame_done); end
        read_px(0, 1, c, v);
        checks++; if (c !== 3'd0) begin errors++; $display("FAIL drops_alias_read got %0d want 0", c); end
        read_px(159, 119, c, v);
        checks++; if (c !== 3'd0) begin errors++; $display("FAIL drops_corner_read got %0d want 0", c); end
    endtask

    task automatic test_read_write_same();
        logic [2:0] c;
        logic v;
        vga_x = 8'd10; vga_y = 7'd10; vga_colour = 3'd6; vga_plot = 1'b1;
        rd_x = 8'd10; rd_y = 7'd10; rd_req = 1'b1;
        tick();
        vga_plot = 1'b0; rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_colour !== 3'd0) begin errors++; $display("FAIL rw_same_old got v=%0b c=%0d want v=1 c=0", rd_valid, rd_colour); end
        checks++; if (plot_count !== 16'd1) begin errors++; $display("FAIL rw_same_plot_count got %0d want 1", plot_count); end
        read_px(10, 10, c, v);
        checks++; if (c !== 3'd6) begin errors++; $display("FAIL rw_same_new got %0d want 6", c); end
    endtask

    task automatic test_coverage_order();
        int bad;
        logic [2:0] c;
        logic v;
        vga_x = 8'd159; vga_y = 7'd119; vga_colour = 3'd7; vga_plot = 1'b1;
        tick();
        checks++; if (frame_done !== EXP_EARLY_DONE) begin errors++; $display("FAIL order_first_done got %0b want %0b", frame_done, EXP_EARLY_DONE); end
        bad = 0;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                if (!(x == 159 && y == 119)) begin
                    vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(x);
                    tick();
                    if (!(x == 158 && y == 119) && frame_done !== EXP_EARLY_DONE) bad++;
                end
            end
        end
        vga_plot = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL order_done_early got %0d wrong cycles want 0", bad); end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL order_done_final got %0b want 1", frame_done); end
        checks++; if (plot_count !== 16'd19201) begin errors++; $display("FAIL order_plot_count got %0d want 19201", plot_count); end
        checks++; if (drop_count !== 8'd4) begin errors++; $display("FAIL order_drop_count got %0d want 4", drop_count); end
        read_px(159, 119, c, v);
        checks++; if (c !== 3'd7) begin errors++; $display("FAIL order_read_corner got %0d want 7", c); end
        read_px(10, 10, c, v);
        checks++; if (c !== 3'd2) begin errors++; $display("FAIL order_read_overwrite got %0d want 2", c); end
    endtask

    task automatic test_clear_mid_fill();
        int n;
        logic [2:0] c;
        logic v;
        int rx[5] = '{0, 10, 50, 159, 13};
        int ry[5] = '{0, 10, 50, 119, 7};
        vga_plot = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            vga_x = 8'(i % 160); vga_y = 7'(i / 160); vga_colour = 3'd3;
            tick();
        end
        checks++; if (plot_count !== 16'd24201) begin errors++; $display("FAIL midclr_plot_count_before got %0d want 24201", plot_count); end
        vga_x = 8'd50; vga_y = 7'd50; vga_colour = 3'd5; clear_req = 1'b1;
        tick();
        clear_req = 1'b0; vga_plot = 1'b0;
        checks++; if (plot_count !== 16'd0) begin errors++; $display("FAIL midclr_plot_count got %0d want 0", plot_count); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL midclr_drop_count got %0d want 0", drop_count); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midclr_frame_done got %0b want 0", frame_done); end
        n = 0;
        while (ready !== 1'b1 && n < 20000) begin
            n++;
            tick();
        end
        checks++; if (n != 19200) begin errors++; $display("FAIL midclr_clear_cycles got %0d want 19200", n); end
        for (int i = 0; i < 5; i++) begin
            read_px(rx[i], ry[i], c, v);
            checks++; if (c !== 3'd0) begin errors++; $display("FAIL midclr_read(%0d,%0d) got %0d want 0", rx[i], ry[i], c); end
        end
        checks++; if (plot_count !== 16'd0) begin errors++; $display("FAIL midclr_plot_count_after got %0d want 0", plot_count); end
    endtask

    task automatic test_raster_fill();
        logic pre_last;
        logic [2:0] c;
        logic v;
        pre_last = 1'bx;
        vga_plot = 1'b1;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(x);
                tick();
                if (x == 158 && y == 119) pre_last = frame_done;
            end
        end
        vga_plot = 1'b0;
        checks++; if (pre_last !== 1'b0) begin errors++; $display("FAIL raster_done_before_last got %0b want 0", pre_last); end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL raster_done got %0b want 1", frame_done); end
        checks++; if (plot_count !== 16'd19200) begin errors++; $display("FAIL raster_plot_count got %0d want 19200", plot_count); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL raster_drop_count got %0d want 0", drop_count); end
        read_px(13, 7, c, v);
        checks++; if (c !== 3'd5) begin errors++; $display("FAIL raster_read_13_7 got %0d want 5", c); end
        read_px(159, 119, c, v);
        checks++; if (c !== 3'd7) begin errors++; $display("FAIL raster_read_corner got %0d want 7", c); end
        read_px(200, 5, c, v);
        checks++; if (v !== 1'b1 || c !== 3'd0) begin errors++; $display("FAIL raster_read_oob got v=%0b c=%0d want v=1 c=0", v, c); end
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL raster_rd_valid_idle got %0b want 0", rd_valid); end
    endtask

    initial begin
        test_reset();
        test_drops();
        test_read_write_same();
        test_coverage_order();
        test_clear_mid_fill();
        test_raster_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/plot_receiver.md
# plot_receiver

Pixel-plot sink for the 160x120, 3-bit-colour VGA plot interface. It accepts plot requests (x, y, colour, plot strobe) from drawing engines such as the fill-screen and shape renderers, writes them into an internal framebuffer, and provides a registered read port for scanout or for checking. It also tracks plot statistics and raises a frame-complete flag, so a bench or top level can tell when a drawing engine has finished the screen.

## Interface
- `W`, 160: screen width in pixels.
- `H`, 120: screen height in pixels.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `vga_x`  in  8  plot x coordinate.
- `vga_y`  in  7  plot y coordinate.
- `vga_colour`  in  3  plot colour.
- `vga_plot`  in  1  plot strobe; one pixel per cycle while high.
- `clear_req`  in  1  one-cycle pulse that starts a framebuffer clear.
- `rd_req`  in  1  read strobe.
- `rd_x`  in  8  read x coordinate.
- `rd_y`  in  7  read y coordinate.
- `ready`  out  1  high when plots are accepted.
- `rd_valid`  out  1  read data valid; asserts one cycle after `rd_req`.
- `rd_colour`  out  3  read data.
- `frame_done`  out  1  sticky frame-complete flag.
- `plot_count`  out  16  accepted plots; saturates at 65535.
- `drop_count`  out  8  dropped plots; saturates at 255.

## Operation
- Framebuffer: W*H = 19200 entries of 3 bits. Address = y*160 + x, computed as (y<<7)+(y<<5)+x in 15 bits.
- FSM has two states, CLEAR and ACTIVE.
- CLEAR:
  - Entered on `rst` or on `clear_req`.
  - A 15-bit clear address runs 0..19199 and writes colour 0 at one address per cycle.
  - `ready`=0 throughout.
  - On the cycle that writes address 19199, the next state is ACTIVE.
  - Entering CLEAR clears `frame_done`, `plot_count`, `drop_count` and the coverage state. The clear address restarts from 0.
  - `clear_req` during CLEAR restarts the clear from address 0.
- ACTIVE:
  - `ready`=1.
  - A plot with x<W and y<H is accepted: the framebuffer is written and `plot_count` is incremented.
  - A plot with x>=W or y>=H is dropped: `drop_count` is incremented and memory is unchanged.
  - A plot while `ready`=0 (i.e. in CLEAR) is also dropped and counted in `drop_count`.
- Read port:
  - Valid in both states.
  - An out-of-range read returns 0, still with `rd_valid`=1.
  - When a read and a write hit the same address in the same cycle, the read returns the old data (read-first).
- `frame_done`: rises per the Configuration section, stays set until the next CLEAR.
- Repeated plots to the same pixel overwrite it (last write wins) and each one counts in `plot_count`.

## Timing
- Reset values: `ready`=0, `rd_valid`=0, `rd_colour`=0, `frame_done`=0, `plot_count`=0, `drop_count`=0. State is CLEAR with clear address 0.
- Clear duration is exactly 19200 cycles. The first cycle in which `ready`=1 is the 19201st rising edge after the edge that sampled `rst`=1 and then `rst`=0.
- A plot written at edge N is visible to a read sampled at edge N+1; that read's data is returned at edge N+2.
- `plot_count`, `drop_count` and `frame_done` update on the same edge that samples the plot.
- `rst` asserted mid-clear or mid-drawing takes effect at the next edge; there is no partial state.
- `clear_req` and `vga_plot` in the same ACTIVE cycle: the clear wins, and the plot is dropped but not counted, because the counters are zeroed.

## Configuration
- `PLOT_RX_COVERAGE_EN` defined:
  - Adds a 19200-bit written-since-clear bitmap and a 15-bit unique-pixel counter.
  - `frame_done` sets when the unique count reaches 19200, i.e. every in-range pixel has been plotted at least once since the last clear.
  - The bitmap is cleared during CLEAR, in parallel with the framebuffer clear.
- `PLOT_RX_COVERAGE_EN` undefined:
  - No bitmap.
  - `frame_done` sets on the first accepted plot at (W-1, H-1) = (159, 119).

## Test plan
- Reset, then idle: `ready`=0 for 19200 cycles and 1 on the next cycle. Reading (0,0), (159,119) and (80,60) returns 0.
- Raster fill, colour = x[2:0], all 19200 pixels in order: `plot_count`=19200, `drop_count`=0, `frame_done`=1 on the edge that samples (159,119). Read (13,7) returns 5.
- Plots at (160,0), (0,120) and (255,127): `drop_count`=3, `plot_count`=0, framebuffer unchanged.
- With `PLOT_RX_COVERAGE_EN`: plot (159,119) first, then the other 19199 pixels. `frame_done` stays 0 after the first plot and sets only on the final plot. Without the macro, `frame_done`=1 immediately after the first plot.
- Read and write of (10,10) in the same cycle, old value 0, new value 6: `rd_colour`=0. A repeat read on the next cycle returns 6.
- `clear_req` pulsed mid-fill after 5000 plots: counters are 0 next cycle, `ready`=0 for 19200 cycles, and afterwards every read returns 0.
